// File: rtl/a2_pkg.sv
// Shared types and constants for the 16-requester round-robin scheduler.
package a2_pkg;
    localparam int N = 16;
    localparam int W = 4;

    typedef enum logic {IDLE, GRANT} state_t;
    typedef logic [N-1:0] req_vec_t;
    typedef logic [W-1:0] idx_t;
endpackage

// File: rtl/prio_enc16.sv
// Lowest-set-bit 16-to-4 priority encoder; purely combinational.
// o_vld is low (and o_idx zero) when no input bit is set.
module prio_enc16
    import a2_pkg::*;
(
    input  req_vec_t i_vec,
    output idx_t     o_idx,
    output logic     o_vld
);

    always_comb begin
        o_idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = W'(i);
            end
        end
        o_vld = |i_vec;
    end

endmodule

// File: rtl/a2_3_rr_sched.sv
// Round-robin scheduler: one grant at a time among 16 requesters, released on
// ack, request drop, or MAX_HOLD expiry (timeout pulse). Outputs registered.
module a2_3_rr_sched
    import a2_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  logic     clk,
    input  logic     rst_n,
    input  req_vec_t req,
    input  logic     gnt_ack,
    output logic     gnt_valid,
    output idx_t     gnt_idx,
    output req_vec_t gnt_onehot,
    output logic     timeout
);

    localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t          r_state;
    logic            r_gnt_valid;
    idx_t            r_gnt_idx;
    req_vec_t        r_gnt_onehot;
    logic            r_timeout;
    idx_t            r_ptr;
    logic [HC_W-1:0] r_hold_cnt;

    state_t          w_state_nxt;
    logic            w_valid_nxt;
    idx_t            w_idx_nxt;
    req_vec_t        w_onehot_nxt;
    logic            w_timeout_nxt;
    idx_t            w_ptr_nxt;
    logic [HC_W-1:0] w_hold_nxt;

    req_vec_t w_masked;
    idx_t     w_m_idx;
    logic     w_m_vld;
    idx_t     w_u_idx;
    logic     w_u_vld;
    idx_t     w_winner;
    logic     w_release;

    // Requesters below the pointer lose priority this round.
    assign w_masked = req & ~((req_vec_t'(1) << r_ptr) - req_vec_t'(1));

    prio_enc16 u_enc_masked (
        .i_vec (w_masked),
        .o_idx (w_m_idx),
        .o_vld (w_m_vld)
    );

    prio_enc16 u_enc_unmasked (
        .i_vec (req),
        .o_idx (w_u_idx),
        .o_vld (w_u_vld)
    );

    assign w_winner  = w_m_vld ? w_m_idx : w_u_idx;
    assign w_release = gnt_ack | ~req[r_gnt_idx];

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = r_gnt_valid;
        w_idx_nxt     = r_gnt_idx;
        w_onehot_nxt  = r_gnt_onehot;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        case (r_state)
            IDLE: begin
                w_valid_nxt  = 1'b0;
                w_onehot_nxt = '0;
                if (w_u_vld) begin
                    w_state_nxt  = GRANT;
                    w_idx_nxt    = w_winner;
                    w_onehot_nxt = req_vec_t'(1) << w_winner;
                    w_valid_nxt  = 1'b1;
                    w_hold_nxt   = '0;
                end
            end
            GRANT: begin
                // Ack has priority over expiry so a same-cycle ack never reports a timeout.
                if (w_release) begin
                    w_state_nxt  = IDLE;
                    w_valid_nxt  = 1'b0;
                    w_onehot_nxt = '0;
                    w_ptr_nxt    = r_gnt_idx + idx_t'(1);
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST)) begin
                    w_state_nxt   = IDLE;
                    w_valid_nxt   = 1'b0;
                    w_onehot_nxt  = '0;
                    w_timeout_nxt = 1'b1;
                    w_ptr_nxt     = r_gnt_idx + idx_t'(1);
                end else if (r_hold_cnt != '1) begin
                    w_hold_nxt = r_hold_cnt + HC_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt_valid  <= 1'b0;
            r_gnt_idx    <= '0;
            r_gnt_onehot <= '0;
            r_timeout    <= 1'b0;
            r_ptr        <= '0;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt_valid  <= w_valid_nxt;
            r_gnt_idx    <= w_idx_nxt;
            r_gnt_onehot <= w_onehot_nxt;
            r_timeout    <= w_timeout_nxt;
            r_ptr        <= w_ptr_nxt;
            r_hold_cnt   <= w_hold_nxt;
        end
    end

    assign gnt_valid  = r_gnt_valid;
    assign gnt_idx    = r_gnt_idx;
    assign gnt_onehot = r_gnt_onehot;
    assign timeout    = r_timeout;

endmodule
